// File: rtl/calculator_seq.sv
// rtl/calculator_seq.sv - registered calculator with handshakes and iterative restoring divider
module calculator_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [CW-1:0]      cnt;
    logic               op_mod;

    logic               accept;
    logic               start_div;
    logic               last_iter;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_ovf;
    logic               alu_dz;

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   rem_step;

    assign accept    = (state == IDLE) && in_valid && !rst;
    assign start_div = ((opcode == 4'd4) || (opcode == 4'd5)) && (input2 != '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Single-cycle operations, evaluated directly on the inputs so the acceptance edge registers them
    always_comb begin
        sum        = {1'b0, input1} + {1'b0, input2};
        prod       = {{WIDTH{1'b0}}, input1} * {{WIDTH{1'b0}}, input2};
        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_dz     = 1'b0;
        case (opcode)
            4'd0, 4'd1: begin
                alu_result = sum[WIDTH-1:0];
                alu_ovf    = sum[WIDTH];
            end
            4'd2: begin
                alu_result = input1 - input2;
                alu_ovf    = (input1 < input2);
            end
            4'd3: begin
                alu_result = prod[WIDTH-1:0];
                alu_ovf    = |prod[2*WIDTH-1:WIDTH];
            end
            4'd4: begin
                alu_result = '1;
                alu_dz     = 1'b1;
            end
            4'd5: begin
                alu_result = input1;
                alu_dz     = 1'b1;
            end
            4'd6:    alu_result = {{(WIDTH-1){1'b0}}, (input1 != '0) && (input2 != '0)};
            4'd7:    alu_result = {{(WIDTH-1){1'b0}}, (input1 != '0) || (input2 != '0)};
            4'd8:    alu_result = ~input1;
            4'd9:    alu_result = {{(WIDTH-1){1'b0}}, input1 < input2};
            4'd10:   alu_result = {{(WIDTH-1){1'b0}}, input1 == input2};
            4'd11:   alu_result = {{(WIDTH-1){1'b0}}, input1 > input2};
            default: alu_result = '0;
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        trial    = rem_sh - {1'b0, divisor};
        quo_step = {quo[WIDTH-2:0], ~trial[WIDTH]};
        rem_step = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; in_ready is masked during reset
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_next = start_div ? DIV : HOLD;
                end
            end
            DIV: begin
                if (last_iter) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, divider iteration and result registers (written only on entry to HOLD)
    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            divisor  <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            op_mod   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        divisor <= input2;
                        quo     <= input1;
                        rem     <= '0;
                        cnt     <= '0;
                        op_mod  <= (opcode == 4'd5);
                        if (!start_div) begin
                            result   <= alu_result;
                            overflow <= alu_ovf;
                            div_zero <= alu_dz;
                        end
                    end
                end
                DIV: begin
                    quo <= quo_step;
                    rem <= rem_step;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        result   <= op_mod ? rem_step : quo_step;
                        overflow <= 1'b0;
                        div_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculator_seq.sv
// tb/tb_calculator_seq.sv - randomized and directed self-checking bench for calculator_seq
module tb_calculator_seq;

    localparam int W  = 8;
    localparam int W2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, overflow, div_zero;
    logic [W-1:0]  input1, input2, result;
    logic [3:0]    opcode;

    logic          in_valid_w, in_ready_w, out_valid_w, out_ready_w, overflow_w, div_zero_w;
    logic [W2-1:0] input1_w, input2_w, result_w;
    logic [3:0]    opcode_w;

    int     total = 0;
    int     bad   = 0;
    longint last_res;

    calculator_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .input1(input1), .input2(input2), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .div_zero(div_zero)
    );

    calculator_seq #(.WIDTH(W2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .input1(input1_w), .input2(input2_w), .opcode(opcode_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .result(result_w),
        .overflow(overflow_w), .div_zero(div_zero_w)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the opcode table written as plain integer arithmetic
    task automatic model(input int w, input int op, input longint a, input longint b,
                         output longint r, output longint ovf, output longint dz);
        longint mask;
        longint t;
        mask = (longint'(1) << w) - 1;
        r = 0; ovf = 0; dz = 0;
        case (op)
            0, 1: begin t = a + b; r = t & mask; ovf = (t > mask); end
            2:    begin r = (a - b) & mask; ovf = (a < b); end
            3:    begin t = a * b; r = t & mask; ovf = ((t >> w) != 0); end
            4:    begin if (b == 0) begin r = mask; dz = 1; end else r = a / b; end
            5:    begin if (b == 0) begin r = a;    dz = 1; end else r = a % b; end
            6:    r = (a != 0 && b != 0);
            7:    r = (a != 0 || b != 0);
            8:    r = (~a) & mask;
            9:    r = (a < b);
            10:   r = (a == b);
            11:   r = (a > b);
            default: r = 0;
        endcase
    endtask

    function automatic int exp_latency(input int w, input int op, input longint b);
        return ((op == 4 || op == 5) && b != 0) ? w + 1 : 1;
    endfunction

    // One full transaction on the 8-bit instance; hold = cycles of backpressure with a competing in_valid
    task automatic do_op(input longint a, input longint b, input int op, input int hold);
        longint er, eo, ez;
        int n, lat;
        logic [W-1:0] held;
        model(W, op, a, b, er, eo, ez);
        @(negedge clk);
        input1 = a[W-1:0]; input2 = b[W-1:0]; opcode = op[3:0];
        in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        input1 = W'($urandom); input2 = W'($urandom); opcode = 4'($urandom);
        lat = 1;
        @(negedge clk);
        if (!out_valid) check("busy_in_ready", in_ready, 0);
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        check("latency", lat, exp_latency(W, op, b));
        check("result", result, er);
        check("overflow", overflow, eo);
        check("div_zero", div_zero, ez);
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            input1 = W'($urandom); input2 = W'($urandom); opcode = 4'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, held);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("consumed_valid", out_valid, 0);
        check("held_after_consume", result, held);
        check("idle_in_ready", in_ready, 1);
        last_res = held;
    endtask

    task automatic do_op_w(input longint a, input longint b, input int op);
        longint er, eo, ez;
        int n, lat;
        model(W2, op, a, b, er, eo, ez);
        @(negedge clk);
        input1_w = a[W2-1:0]; input2_w = b[W2-1:0]; opcode_w = op[3:0];
        in_valid_w = 1'b1; out_ready_w = 1'b0;
        n = 0;
        while (!in_ready_w && n < 50) begin @(negedge clk); n++; end
        if (!in_ready_w) begin
            check("w16_accept_timeout", 0, 1);
            in_valid_w = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid_w = 1'b0;
        input1_w = W2'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid_w && lat < 50) begin @(negedge clk); lat++; end
        check("w16_latency", lat, exp_latency(W2, op, b));
        check("w16_result", result_w, er);
        check("w16_overflow", overflow_w, eo);
        check("w16_div_zero", div_zero_w, ez);
        out_ready_w = 1'b1;
        @(posedge clk);
        #1;
        out_ready_w = 1'b0;
    endtask

    function automatic longint pick(input int w);
        longint mask;
        mask = (longint'(1) << w) - 1;
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return mask;
            default: return longint'($urandom) & mask;
        endcase
    endfunction

    initial begin
        int t1_ops[9];
        int t1_res[9];
        t1_ops = '{0, 2, 3, 6, 7, 8, 9, 10, 11};
        t1_res = '{15, 5, 50, 1, 1, 245, 0, 0, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        input1 = '0; input2 = '0; opcode = '0;
        in_valid_w = 1'b0; out_ready_w = 1'b0;
        input1_w = '0; input2_w = '0; opcode_w = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_result", result, 0);
        check("post_rst_overflow", overflow, 0);
        check("post_rst_div_zero", div_zero, 0);

        for (int i = 0; i < 9; i++) begin
            do_op(10, 5, t1_ops[i], 0);
            check("t1_const", last_res, t1_res[i]);
        end

        do_op(200, 100, 0, 0); check("t2_add", last_res, 44);
        do_op(5, 10, 2, 0);    check("t2_sub", last_res, 251);
        do_op(16, 16, 3, 0);   check("t2_mul", last_res, 0);

        do_op(10, 3, 4, 0);    check("t3_div", last_res, 3);
        do_op(10, 3, 5, 0);    check("t3_mod", last_res, 1);
        do_op(255, 1, 4, 0);   check("t3_div255", last_res, 255);

        do_op(7, 0, 4, 0);     check("t4_div0", last_res, 255);
        do_op(7, 0, 5, 0);     check("t4_mod0", last_res, 7);

        do_op(33, 4, 3, 5);
        do_op(77, 9, 5, 5);

        // Reset in the middle of a divide
        @(negedge clk);
        input1 = 8'd10; input2 = 8'd3; opcode = 4'd4; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_in_ready_after", in_ready, 1);
        do_op(1, 1, 0, 0);
        check("t6_add", last_res, 2);

        for (int i = 0; i < 80; i++) begin
            do_op(pick(W), pick(W), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        do_op_w(1000, 7, 4);
        do_op_w(1000, 7, 5);
        for (int i = 0; i < 12; i++) begin
            do_op_w(pick(W2), pick(W2), int'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
